// File: rtl/lfsr_prng.sv
// lfsr_prng -- parametrised Fibonacci LFSR pseudo-random source.
//
// Generalises the fixed 10-bit XNOR LFSR. Width, feedback taps and XOR/XNOR
// feedback are configurable. The state can advance several shifts per clock.
// Seeds can be loaded at run time, and a seed equal to the lock-up value is
// rejected. The block also measures the sequence period in hardware.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high reset
//   en        in   1      advance the state by STEPS shifts this cycle
//   load      in   1      load seed_in into the state (priority over en)
//   seed_in   in   WIDTH  seed sampled when load=1
//   q         out  WIDTH  current LFSR state, registered
//   load_err  out  1      one-cycle pulse: the last load hit the lock-up value
//   wrap      out  1      one-cycle pulse: the state just returned to its start value
//   period    out  CNT_W  step count of the last completed cycle, 0 until the first wrap

module lfsr_prng #(
  parameter int          WIDTH      = 10,
  parameter int unsigned TAPS       = 'h240,
  parameter int          USE_XNOR   = 1,
  parameter int          STEPS      = 1,
  parameter int unsigned RESET_SEED = 0,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q,
  output logic             load_err,
  output logic             wrap,
  output logic [CNT_W-1:0] period
);

  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED0    = RESET_SEED[WIDTH-1:0];
  // XNOR feedback can never leave all-ones; XOR feedback can never leave all-zeros.
  localparam logic [WIDTH-1:0] LOCK     = (USE_XNOR != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  // Elaboration-time parameter checks.
  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_prng: WIDTH must be in 3..32");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_prng: STEPS must be in 1..WIDTH");
  end
  if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
    $error("lfsr_prng: TAPS[WIDTH-1] must be set");
  end
  if (SEED0 == LOCK) begin : g_bad_seed
    $error("lfsr_prng: RESET_SEED equals the lock-up value");
  end

  logic [WIDTH-1:0] start;     // state at which the current cycle began
  logic [CNT_W-1:0] cnt;       // shifts since start
  logic [WIDTH-1:0] q_step;    // q advanced by STEPS shifts
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_add;   // cnt + STEPS, saturating

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s);
    logic fb;
    fb = ^(s & TAP_MASK);
    if (USE_XNOR != 0) fb = ~fb;
    return {s[WIDTH-2:0], fb};
  endfunction

  // NOTE: every variable written here gets a value before any conditional
  // logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_step = q;
    for (int i = 0; i < STEPS; i++) q_step = shift1(q_step);
    cnt_sum = {1'b0, cnt} + (CNT_W+1)'(STEPS);
    cnt_add = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q        <= SEED0;
      start    <= SEED0;
      cnt      <= '0;
      period   <= '0;
      load_err <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      load_err <= 1'b0;
      wrap     <= 1'b0;
      if (load) begin
        if (seed_in == LOCK) begin
          load_err <= 1'b1;
        end else begin
          q      <= seed_in;
          start  <= seed_in;
          cnt    <= '0;
          period <= '0;
        end
      end else if (en) begin
        q <= q_step;
        if (q_step == start) begin
          wrap   <= 1'b1;
          period <= cnt_add;
          cnt    <= '0;
        end else begin
          cnt <= cnt_add;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng. It uses three instances: the default 10-bit XNOR
// configuration (a), STEPS=2 (b), and a 4-bit XOR configuration (c). Stimulus
// pushes hand-computed expectations after each clock edge. A monitor on the
// falling edge pops them and compares them against the instance named in the
// entry.

module tb_lfsr_prng;

  typedef struct {
    int          sel;
    string       name;
    bit          chk_q;
    logic [31:0] q;
    logic        wrap;
    logic        load_err;
    bit          chk_p;
    logic [31:0] period;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic en_a, load_a, en_b, load_b, en_c, load_c;
  logic [9:0]  seed_a, seed_b, q_a, q_b;
  logic [3:0]  seed_c, q_c;
  logic        le_a, le_b, le_c, w_a, w_b, w_c;
  logic [31:0] p_a, p_b, p_c;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  lfsr_prng u_a (
    .clk(clk), .reset(reset), .en(en_a), .load(load_a), .seed_in(seed_a),
    .q(q_a), .load_err(le_a), .wrap(w_a), .period(p_a));

  lfsr_prng #(.STEPS(2)) u_b (
    .clk(clk), .reset(reset), .en(en_b), .load(load_b), .seed_in(seed_b),
    .q(q_b), .load_err(le_b), .wrap(w_b), .period(p_b));

  lfsr_prng #(.WIDTH(4), .TAPS('hC), .USE_XNOR(0), .RESET_SEED(1)) u_c (
    .clk(clk), .reset(reset), .en(en_c), .load(load_c), .seed_in(seed_c),
    .q(q_c), .load_err(le_c), .wrap(w_c), .period(p_c));

  task automatic push(input int sel, input string name, input bit chk_q,
                      input logic [31:0] q, input logic w, input logic le,
                      input bit chk_p, input logic [31:0] p);
    exp_t e;
    e.sel = sel; e.name = name; e.chk_q = chk_q; e.q = q;
    e.wrap = w; e.load_err = le; e.chk_p = chk_p; e.period = p;
    sb.push_back(e);
  endtask

  // Monitor: compares everything pushed since the last rising edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] aq, ap;
      logic        aw, al;
      e = sb.pop_front();
      case (e.sel)
        0:       begin aq = {22'd0, q_a}; aw = w_a; al = le_a; ap = p_a; end
        1:       begin aq = {22'd0, q_b}; aw = w_b; al = le_b; ap = p_b; end
        default: begin aq = {28'd0, q_c}; aw = w_c; al = le_c; ap = p_c; end
      endcase
      vectors++;
      if ((e.chk_q && aq !== e.q) || aw !== e.wrap || al !== e.load_err ||
          (e.chk_p && ap !== e.period)) begin
        miscompares++;
        $display("FAIL %s[%0d]: got q=%h wrap=%b load_err=%b period=%0d, want q=%h wrap=%b load_err=%b period=%0d",
                 e.name, e.sel, aq, aw, al, ap, e.q, e.wrap, e.load_err, e.period);
      end
    end
  end

  logic [9:0] tab_a [8];
  logic [3:0] tab_c [15];
  logic [9:0] tab_b [3];

  initial begin
    tab_a = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F, 10'h0FE};
    tab_b = '{10'h003, 10'h00F, 10'h03F};
    tab_c = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
              4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    reset = 1'b1;
    en_a = 0; load_a = 0; seed_a = '0;
    en_b = 0; load_b = 0; seed_b = '0;
    en_c = 0; load_c = 0; seed_c = '0;

    // Reset state.
    @(posedge clk); #1;
    push(0, "reset", 1, 32'h000, 0, 0, 1, 0);
    push(1, "reset", 1, 32'h000, 0, 0, 1, 0);
    push(2, "reset", 1, 32'h1,   0, 0, 1, 0);
    @(negedge clk); reset = 1'b0;

    // en held from reset: first 8 states, then wrap exactly at step 1023.
    en_a = 1;
    for (int s = 1; s <= 1023; s++) begin
      @(posedge clk); #1;
      if (s <= 8)         push(0, "seq", 1, {22'd0, tab_a[s-1]}, 0, 0, 1, 0);
      else if (s == 1023) push(0, "wrap1", 1, 32'h000, 1, 0, 1, 1023);
      else                push(0, "nowrap1", 0, 0, 0, 0, 1, 0);
    end
    // Second full cycle: wrap again 1023 clocks later.
    for (int s = 1; s <= 1023; s++) begin
      @(posedge clk); #1;
      if (s == 1)         push(0, "cyc2", 1, 32'h001, 0, 0, 1, 1023);
      else if (s == 1023) push(0, "wrap2", 1, 32'h000, 1, 0, 1, 1023);
      else                push(0, "nowrap2", 0, 0, 0, 0, 1, 1023);
    end

    // Hold, then a rejected lock-up load, then a good load.
    @(negedge clk); en_a = 0;
    @(posedge clk); #1; push(0, "hold", 1, 32'h000, 0, 0, 1, 1023);
    @(negedge clk); load_a = 1; seed_a = 10'h3FF;
    @(posedge clk); #1; push(0, "lockload", 1, 32'h000, 0, 1, 1, 1023);
    @(negedge clk); load_a = 0;
    @(posedge clk); #1; push(0, "errpulse", 1, 32'h000, 0, 0, 1, 1023);
    @(negedge clk); load_a = 1; seed_a = 10'h155;
    @(posedge clk); #1; push(0, "load155", 1, 32'h155, 0, 0, 1, 0);
    // load and en together: load wins, no shift.
    @(negedge clk); load_a = 1; en_a = 1; seed_a = 10'h0AA;
    @(posedge clk); #1; push(0, "loaden", 1, 32'h0AA, 0, 0, 1, 0);
    @(negedge clk); load_a = 0;
    @(posedge clk); #1; push(0, "step0AA", 1, 32'h155, 0, 0, 1, 0);
    @(posedge clk); #1; push(0, "step155", 1, 32'h2AA, 0, 0, 1, 0);
    @(negedge clk); en_a = 0;

    // 4-bit XOR instance: full 15-step cycle.
    @(negedge clk); en_c = 1;
    for (int s = 1; s <= 15; s++) begin
      @(posedge clk); #1;
      push(2, "c_seq", 1, {28'd0, tab_c[s-1]}, s == 15, 0, 1, (s == 15) ? 15 : 0);
    end
    @(posedge clk); #1; push(2, "c_after", 1, 32'h2, 0, 0, 1, 15);
    @(negedge clk); en_c = 0; load_c = 1; seed_c = 4'h0;
    @(posedge clk); #1; push(2, "c_lockload", 1, 32'h2, 0, 1, 1, 15);
    @(negedge clk); load_c = 0;
    @(posedge clk); #1; push(2, "c_errpulse", 1, 32'h2, 0, 0, 1, 15);

    // STEPS=2 instance.
    @(negedge clk); en_b = 1;
    for (int s = 1; s <= 3; s++) begin
      @(posedge clk); #1;
      push(1, "b_seq", 1, {22'd0, tab_b[s-1]}, 0, 0, 1, 0);
    end

    // Asynchronous reset mid-run, between clock edges.
    @(negedge clk); en_a = 1;
    @(posedge clk); #2; reset = 1'b1; #1;
    push(0, "async_rst", 1, 32'h000, 0, 0, 1, 0);
    push(1, "async_rst", 1, 32'h000, 0, 0, 1, 0);
    push(2, "async_rst", 1, 32'h1,   0, 0, 1, 0);
    @(negedge clk); #1;

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
